// File: rtl/ls368_bus_arbiter.sv
// ls368_bus_arbiter
//
// Round-robin arbiter and sequencer for a shared tri-state bus. The bus is built from
// LS368A-style hex inverting 3-state buffers, one buffer per requester. Each buffer has two
// sections: a 4-bit section enabled on pin 1 and a 2-bit section enabled on pin 15.
//
// Request lines are turned into registered, mutually exclusive active-low enables. Enforced
// dead cycles (TURN) are inserted between tenures, so no two buffers ever drive the bus in
// the same cycle.
//
// Ports:
//   clk       in   1        system clock, rising edge
//   rst       in   1        asynchronous active-high reset
//   req       in   NUM_REQ  per-requester bus request, held high for the whole tenure
//   need_hi   in   NUM_REQ  requester also needs the 2-bit section (sampled at grant only)
//   gnt       out  NUM_REQ  one-hot registered grant
//   en_lo_b   out  NUM_REQ  active-low enable, 4-bit section (pin 1)
//   en_hi_b   out  NUM_REQ  active-low enable, 2-bit section (pin 15)
//   bus_idle  out  1        arbiter in IDLE with every buffer disabled
//   timeout   out  1        one-cycle pulse when a tenure is forcibly ended
//
// Optional feature:
//   LS368_BUS_ARB_TIMEOUT_EN - when defined, a tenure is cut off after MAX_HOLD cycles.
//   When undefined, tenures are unbounded and timeout is tied low.

module ls368_bus_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] need_hi,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] en_lo_b,
  output logic [NUM_REQ-1:0] en_hi_b,
  output logic               bus_idle,
  output logic               timeout
);

  localparam int unsigned     PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0]      TurnLoad = 3'(TURNAROUND - 1);
  localparam logic [PtrW-1:0] LastIdx  = PtrW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] en_lo_b_q;
  logic [NUM_REQ-1:0] en_hi_b_q;
  logic               bus_idle_q;
  logic [PtrW-1:0]    ptr_q;
  logic [2:0]         turn_cnt_q;

  logic [PtrW-1:0]    winner;
  logic [PtrW-1:0]    idx;
  logic [PtrW-1:0]    ptr_next;
  logic [NUM_REQ-1:0] win_onehot;
  logic               req_held;

`ifdef LS368_BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q;
  logic       timeout_q;
  logic       hold_expire;

  assign hold_expire = (hold_q == HoldLast);
  assign timeout     = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search. Candidates are scanned from the farthest position down to the
  // pointer, so the last hit written is the first requester at or above the pointer.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PtrW'((32'(ptr_q) + (NUM_REQ - 1 - k)) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  always_comb begin
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
    ptr_next           = (winner == LastIdx) ? '0 : winner + 1'b1;
  end

  // Only the current owner's request matters during a tenure.
  assign req_held = |(gnt_q & req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      en_lo_b_q  <= '1;
      en_hi_b_q  <= '1;
      bus_idle_q <= 1'b1;
      ptr_q      <= '0;
      turn_cnt_q <= '0;
`ifdef LS368_BUS_ARB_TIMEOUT_EN
      hold_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef LS368_BUS_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            gnt_q      <= win_onehot;
            en_lo_b_q  <= ~win_onehot;
            // need_hi is captured here and held in en_hi_b_q for the whole tenure.
            en_hi_b_q  <= ~(win_onehot & need_hi);
            ptr_q      <= ptr_next;
            bus_idle_q <= 1'b0;
            state_q    <= StGrant;
`ifdef LS368_BUS_ARB_TIMEOUT_EN
            hold_q     <= '0;
`endif
          end
        end

        StGrant: begin
          if (!req_held) begin
            gnt_q      <= '0;
            en_lo_b_q  <= '1;
            en_hi_b_q  <= '1;
            turn_cnt_q <= TurnLoad;
            state_q    <= StTurn;
          end
`ifdef LS368_BUS_ARB_TIMEOUT_EN
          else if (hold_expire) begin
            // Forced release: identical to a voluntary one, plus the timeout pulse.
            gnt_q      <= '0;
            en_lo_b_q  <= '1;
            en_hi_b_q  <= '1;
            turn_cnt_q <= TurnLoad;
            state_q    <= StTurn;
            timeout_q  <= 1'b1;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
`endif
        end

        StTurn: begin
          // Requests are not looked at here; arbitration resumes from IDLE.
          if (turn_cnt_q == 3'd0) begin
            state_q    <= StIdle;
            bus_idle_q <= 1'b1;
          end else begin
            turn_cnt_q <= turn_cnt_q - 3'd1;
          end
        end

        default: begin
          state_q    <= StIdle;
          gnt_q      <= '0;
          en_lo_b_q  <= '1;
          en_hi_b_q  <= '1;
          bus_idle_q <= 1'b1;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign en_lo_b  = en_lo_b_q;
  assign en_hi_b  = en_hi_b_q;
  assign bus_idle = bus_idle_q;

`ifndef SYNTHESIS
  // Bus contention guards: never two drivers, never an enable without its grant.
  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_q));
      assert ((~en_lo_b_q & ~gnt_q) == '0);
      assert ((~en_hi_b_q & ~gnt_q) == '0);
    end
  end

  always @(posedge clk) begin
    assert (NUM_REQ >= 2 && NUM_REQ <= 8 && TURNAROUND >= 1 && TURNAROUND <= 7 &&
            MAX_HOLD >= 2 && MAX_HOLD <= 255);
  end
`endif

endmodule

// File: tb/tb_ls368_bus_arbiter.sv
// Testbench for ls368_bus_arbiter.
//
// A tenure-level reference model tracks the owner, the remaining dead cycles, the
// round-robin pointer and the tenure length. It is compared with the DUT after every
// clock edge. Directed sections exercise reset, single requests, need_hi latching and
// round robin; a randomized section follows.

module tb_ls368_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TA = 1;
  localparam int unsigned MH = 16;
  localparam int unsigned IW = $clog2(N);
`ifdef LS368_BUS_ARB_TIMEOUT_EN
  localparam bit ToutEn = 1'b1;
`else
  localparam bit ToutEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] need_hi;
  logic [N-1:0] gnt;
  logic [N-1:0] en_lo_b;
  logic [N-1:0] en_hi_b;
  logic         bus_idle;
  logic         timeout;

  ls368_bus_arbiter #(
    .NUM_REQ   (N),
    .TURNAROUND(TA),
    .MAX_HOLD  (MH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .need_hi (need_hi),
    .gnt     (gnt),
    .en_lo_b (en_lo_b),
    .en_hi_b (en_hi_b),
    .bus_idle(bus_idle),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_owner;   // -1 when nobody holds the bus
  int m_cool;    // dead edges still to pass before arbitration may happen
  int m_ptr;
  int m_len;     // cycles of gnt so far in this tenure
  bit m_need;
  bit m_tout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cool  = 0;
    m_ptr   = 0;
    m_len   = 0;
    m_need  = 1'b0;
    m_tout  = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] nh);
    m_tout = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner[IW-1:0]]) begin
        m_owner = -1;
        m_cool  = TA;
      end else if (ToutEn && m_len == int'(MH)) begin
        m_owner = -1;
        m_cool  = TA;
        m_tout  = 1'b1;
      end else begin
        m_len++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        int c;
        c = (m_ptr + k) % int'(N);
        if (r[c[IW-1:0]]) begin
          m_owner = c;
          m_need  = nh[c[IW-1:0]];
          m_len   = 1;
          m_ptr   = (c + 1) % int'(N);
          break;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg;
    logic [N-1:0] elo;
    logic [N-1:0] ehi;
    logic [N-1:0] lo_act;
    logic [N-1:0] hi_act;
    logic         eidle;
    eg = '0;
    if (m_owner >= 0) eg[m_owner[IW-1:0]] = 1'b1;
    elo    = ~eg;
    ehi    = (m_owner >= 0 && m_need) ? ~eg : '1;
    eidle  = (m_owner < 0 && m_cool == 0);
    lo_act = ~en_lo_b;
    hi_act = ~en_hi_b;
    check_eq("gnt", gnt, eg);
    check_eq("en_lo_b", en_lo_b, elo);
    check_eq("en_hi_b", en_hi_b, ehi);
    check_eq("bus_idle", bus_idle, eidle);
    check_eq("timeout", timeout, m_tout);
    check_eq("gnt_onehot0", $onehot0(gnt), 1);
    check_eq("lo_onehot0", $onehot0(lo_act), 1);
    check_eq("hi_onehot0", $onehot0(hi_act), 1);
    check_eq("en_without_gnt", |((lo_act | hi_act) & ~gnt), 0);
  endtask

  // Called at posedge+1: drive, take one edge, update the model, sample at posedge+1.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] nh);
    req     = r;
    need_hi = nh;
    @(posedge clk);
    model_step(r, nh);
    #1;
    compare_model();
  endtask

  // Asserts reset between edges and checks that the outputs drop without a clock edge.
  task automatic pulse_reset(input string tag);
    #3;
    req     = '0;
    need_hi = '0;
    rst     = 1'b1;
    #1;
    check_eq({tag, "_gnt"}, gnt, 0);
    check_eq({tag, "_en_lo_b"}, en_lo_b, 4'b1111);
    check_eq({tag, "_en_hi_b"}, en_hi_b, 4'b1111);
    check_eq({tag, "_bus_idle"}, bus_idle, 1);
    check_eq({tag, "_timeout"}, timeout, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      step('0, '0);
      if (bus_idle) break;
    end
    check_eq("drain_idle", bus_idle, 1);
  endtask

  logic [N-1:0] rv;
  logic [N-1:0] nv;
  logic [N-1:0] prev_g;
  int           held;
  int           gap;
  int           min_gap;
  int           order[$];
  int           hi_cnt;
  int           pulses;
  bit           seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    req     = '0;
    need_hi = '0;
    model_reset();

    // Reset values, checked before the first clock edge.
    #1 rst = 1'b1;
    #2;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_en_lo_b", en_lo_b, 4'b1111);
    check_eq("rst_en_hi_b", en_hi_b, 4'b1111);
    check_eq("rst_bus_idle", bus_idle, 1);
    check_eq("rst_timeout", timeout, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request with the 2-bit section.
    step(4'b0100, 4'b0100);
    check_eq("single_gnt", gnt, 4'b0100);
    check_eq("single_en_lo_b", en_lo_b, 4'b1011);
    check_eq("single_en_hi_b", en_hi_b, 4'b1011);
    step(4'b0000, 4'b0000);
    check_eq("single_rel_lo", en_lo_b, 4'b1111);
    check_eq("single_rel_hi", en_hi_b, 4'b1111);
    check_eq("single_turn_idle", bus_idle, 0);
    step(4'b0000, 4'b0000);
    check_eq("single_idle", bus_idle, 1);

    // need_hi low at grant, toggled during the tenure.
    step(4'b0010, 4'b0000);
    check_eq("nh_en_lo_b", en_lo_b, 4'b1101);
    check_eq("nh_en_hi_b", en_hi_b, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      nv = (i % 2 == 0) ? 4'b1111 : 4'b0010;
      step(4'b0010, nv);
      check_eq("nh_hold_lo", en_lo_b, 4'b1101);
      check_eq("nh_hold_hi", en_hi_b, 4'b1111);
    end
    drain();

    // Reset in the middle of a tenure.
    step(4'b0001, 4'b0001);
    check_eq("mid_gnt", gnt, 4'b0001);
    step(4'b0001, 4'b0001);
    check_eq("mid_en_hi_b", en_hi_b, 4'b1110);
    pulse_reset("async_rst");

    // Round robin with all requesters busy; each releases after 3 cycles of tenure.
    prev_g  = '0;
    held    = 0;
    gap     = 0;
    min_gap = 1000;
    for (int i = 0; i < 80 && order.size() < 5; i++) begin
      rv = (held == 3) ? ~prev_g : 4'b1111;
      step(rv, 4'b1111);
      if (gnt != '0) begin
        if (held == 0) begin
          for (int b = 0; b < int'(N); b++) begin
            if (gnt[b]) order.push_back(b);
          end
          if (order.size() > 1 && gap < min_gap) min_gap = gap;
        end
        held++;
        gap = 0;
      end else begin
        held = 0;
        gap++;
      end
      prev_g = gnt;
    end
    check_eq("rr_count", order.size(), 5);
    foreach (order[i]) check_eq("rr_order", order[i], i % int'(N));
    check_eq("rr_min_gap", (min_gap >= int'(TA) + 1), 1);
    drain();

`ifdef LS368_BUS_ARB_TIMEOUT_EN
    // A held request is cut off after MH cycles.
    hi_cnt = 0;
    pulses = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(4'b0001, 4'b0000);
      if (gnt[0]) begin
        hi_cnt++;
        seen = 1'b1;
      end
      if (timeout) pulses++;
      if (seen && !gnt[0]) break;
    end
    check_eq("tout_len", hi_cnt, MH);
    check_eq("tout_pulses", pulses, 1);
    step(4'b0001, 4'b0000);
    check_eq("tout_turn_gnt", gnt, 0);
    step(4'b0001, 4'b0000);
    check_eq("tout_regrant", gnt, 4'b0001);
    // With another requester pending, the pointer hands the bus to it after the cutoff.
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(4'b0011, 4'b0000);
      if (timeout) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("tout_second", seen, 1);
    step(4'b0011, 4'b0000);
    step(4'b0011, 4'b0000);
    check_eq("tout_other_wins", gnt, 4'b0010);
    drain();
`endif

    // Randomized traffic with requesters that hold and drop their lines.
    rv = '0;
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < int'(N); b++) begin
        if (rv[b]) begin
          if ($urandom_range(0, 7) == 0) rv[b] = 1'b0;
        end else begin
          if ($urandom_range(0, 3) == 0) rv[b] = 1'b1;
        end
      end
      nv = N'($urandom);
      step(rv, nv);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
